// File: rtl/lsu_unit.sv
// ---------------------------------------------------------------------------
// lsu_unit
//
// Load/store functional unit. Issued memory ops (operands already resolved)
// enter an in-order circular queue. They execute one at a time against an
// internal 16-bit data memory. Each completion is broadcast on this unit's
// CDB lane.
//
// Stores are held at the queue head until their ROB index is the oldest one
// in flight (rob_head). Every op behind a store waits for that store, so a
// load never needs data forwarding.
//
// Ports
//   clk             clock; all state updates on the rising edge
//   reset_n         synchronous active-low reset
//   in_instr_valid  issue strobe from the reservation station
//   in_rob_idx      ROB index of the issued op
//   in_opcode       LD_OP, ST_OP or any other (completes with value 0)
//   in_a_value      address operand; the low ADDR_W bits are used
//   in_b_value      store data
//   rob_head        ROB index of the oldest in-flight instruction
//   flush           discard all queued and in-progress ops
//   full            queue full (combinational from the entry count)
//   cdb_valid       single-cycle completion pulse (registered)
//   cdb_rob_idx     ROB index being completed (registered)
//   cdb_value       load data, 0 for other ops (registered)
// ---------------------------------------------------------------------------
module lsu_unit #(
    parameter int         DEPTH  = 4,
    parameter int         ADDR_W = 8,
    parameter logic [3:0] LD_OP  = 4'hA,
    parameter logic [3:0] ST_OP  = 4'hB
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_instr_valid,
    input  logic [3:0]  in_rob_idx,
    input  logic [3:0]  in_opcode,
    input  logic [15:0] in_a_value,
    input  logic [15:0] in_b_value,
    input  logic [3:0]  rob_head,
    input  logic        flush,
    output logic        full,
    output logic        cdb_valid,
    output logic [3:0]  cdb_rob_idx,
    output logic [15:0] cdb_value
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT_HEAD, RESP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [3:0]         cdb_rob_idx_q, cdb_rob_idx_d;
    logic [15:0]        cdb_value_q, cdb_value_d;
    logic [3:0]         resp_idx_q, resp_idx_d;
    logic               resp_is_load_q, resp_is_load_d;

    // Queue storage and data memory (never reset)
    logic [3:0]         q_idx_q  [DEPTH];
    logic [3:0]         q_op_q   [DEPTH];
    logic [ADDR_W-1:0]  q_addr_q [DEPTH];
    logic [15:0]        q_data_q [DEPTH];
    logic [15:0]        mem      [2**ADDR_W];
    logic [15:0]        mem_rd_q;

    logic               enq, pop, mem_we, mem_re;
    logic [3:0]         h_idx;
    logic [3:0]         h_op;
    logic [ADDR_W-1:0]  h_addr;
    logic [15:0]        h_data;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^in_a_value[15:ADDR_W];

    assign full        = (count_q == CNT_W'(DEPTH));
    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_idx = cdb_rob_idx_q;
    assign cdb_value   = cdb_value_q;

    assign h_idx  = q_idx_q[head_q];
    assign h_op   = q_op_q[head_q];
    assign h_addr = q_addr_q[head_q];
    assign h_data = q_data_q[head_q];

    always_comb begin
        state_d        = state_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        cdb_valid_d    = 1'b0;
        cdb_rob_idx_d  = cdb_rob_idx_q;
        cdb_value_d    = cdb_value_q;
        resp_idx_d     = resp_idx_q;
        resp_is_load_d = resp_is_load_q;
        pop            = 1'b0;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        enq            = in_instr_valid && !full;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (h_op == ST_OP) begin
                        if (rob_head == h_idx) begin
                            pop    = 1'b1;
                            mem_we = 1'b1;
                        end else begin
                            state_d = WAIT_HEAD;
                        end
                    end else begin
                        // Loads read synchronously; other ops just retire
                        pop    = 1'b1;
                        mem_re = (h_op == LD_OP);
                    end
                end
            end
            WAIT_HEAD: begin
                if (rob_head == h_idx) begin
                    pop    = 1'b1;
                    mem_we = 1'b1;
                end
            end
            RESP: begin
                cdb_valid_d   = 1'b1;
                cdb_rob_idx_d = resp_idx_q;
                cdb_value_d   = resp_is_load_q ? mem_rd_q : 16'h0000;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            state_d        = RESP;
            resp_idx_d     = h_idx;
            resp_is_load_d = (h_op == LD_OP);
        end

        // Flush and reset override everything, including memory writes
        // and any same-cycle issue.
        if (flush || !reset_n) begin
            state_d     = IDLE;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            cdb_valid_d = 1'b0;
            pop         = 1'b0;
            mem_we      = 1'b0;
            mem_re      = 1'b0;
            enq         = 1'b0;
        end else begin
            head_d  = pop ? head_q + PTR_W'(1) : head_q;
            tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
            count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_rob_idx_q <= 4'h0;
            cdb_value_q   <= 16'h0000;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_rob_idx_q  <= cdb_rob_idx_d;
            cdb_value_q    <= cdb_value_d;
            resp_idx_q     <= resp_idx_d;
            resp_is_load_q <= resp_is_load_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_idx_q[tail_q]  <= in_rob_idx;
            q_op_q[tail_q]   <= in_opcode;
            q_addr_q[tail_q] <= in_a_value[ADDR_W-1:0];
            q_data_q[tail_q] <= in_b_value;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[h_addr] <= h_data;
        end
        if (mem_re) begin
            mem_rd_q <= mem[h_addr];
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
module tb_lsu_unit;
    localparam int         DEPTH = 4;
    localparam logic [3:0] LD    = 4'hA;
    localparam logic [3:0] ST    = 4'hB;
    localparam logic [3:0] OTH   = 4'h3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_instr_valid;
    logic [3:0]  in_rob_idx;
    logic [3:0]  in_opcode;
    logic [15:0] in_a_value;
    logic [15:0] in_b_value;
    logic [3:0]  rob_head;
    logic        flush;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_idx;
    logic [15:0] cdb_value;

    lsu_unit #(.DEPTH(DEPTH), .ADDR_W(8), .LD_OP(LD), .ST_OP(ST)) dut (
        .clk(clk), .reset_n(reset_n), .in_instr_valid(in_instr_valid),
        .in_rob_idx(in_rob_idx), .in_opcode(in_opcode), .in_a_value(in_a_value),
        .in_b_value(in_b_value), .rob_head(rob_head), .flush(flush), .full(full),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] val;
        int          cyc;
    } done_t;

    // Behavioural model: in-order op list, memory image, and one pending
    // broadcast. An op may leave the head on any edge that does not directly
    // follow another departure; a store additionally needs rob_head == idx.
    op_t         mq[$];
    logic [15:0] mem_m [256];
    bit          resp_pend;
    logic [3:0]  r_idx;
    logic [15:0] r_val;
    bit          e_valid;
    logic [3:0]  e_idx;
    logic [15:0] e_val;
    bit          m_acc;

    done_t       dlog[$];
    int          cyc;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        op_t h;
        bit  pre_full;
        m_acc = 1'b0;
        if (!reset_n || flush) begin
            mq.delete();
            resp_pend = 1'b0;
            e_valid   = 1'b0;
            if (!reset_n) begin
                e_idx = 4'h0;
                e_val = 16'h0000;
            end
        end else begin
            pre_full = (mq.size() == DEPTH);
            e_valid  = 1'b0;
            if (resp_pend) begin
                e_valid   = 1'b1;
                e_idx     = r_idx;
                e_val     = r_val;
                resp_pend = 1'b0;
            end else if (mq.size() > 0) begin
                h = mq[0];
                if (h.op != ST || rob_head == h.idx) begin
                    void'(mq.pop_front());
                    r_idx = h.idx;
                    r_val = 16'h0000;
                    if (h.op == LD) r_val = mem_m[h.a[7:0]];
                    if (h.op == ST) mem_m[h.a[7:0]] = h.b;
                    resp_pend = 1'b1;
                end
            end
            if (in_instr_valid && !pre_full) begin
                mq.push_back('{in_rob_idx, in_opcode, in_a_value, in_b_value});
                m_acc = 1'b1;
            end
        end
    endtask

    // One clock: the model advances on the edge, outputs are compared on the
    // following falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        chk("full", {15'd0, full}, {15'd0, mq.size() == DEPTH});
        chk("cdb_valid", {15'd0, cdb_valid}, {15'd0, e_valid});
        if (e_valid) begin
            chk("cdb_rob_idx", {12'd0, cdb_rob_idx}, {12'd0, e_idx});
            chk("cdb_value", cdb_value, e_val);
        end
        if (cdb_valid === 1'b1) dlog.push_back('{cdb_rob_idx, cdb_value, cyc});
    endtask

    task automatic issue(input logic [3:0] idx, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        in_instr_valid = 1'b1;
        in_rob_idx     = idx;
        in_opcode      = op;
        in_a_value     = a;
        in_b_value     = b;
        step();
        in_instr_valid = 1'b0;
    endtask

    // Holds the issue until the queue accepts it (bounded).
    task automatic issue_acc(input logic [3:0] idx, input logic [3:0] op,
                             input logic [15:0] a, input logic [15:0] b);
        int k = 0;
        in_instr_valid = 1'b1;
        in_rob_idx     = idx;
        in_opcode      = op;
        in_a_value     = a;
        in_b_value     = b;
        do begin
            step();
            k++;
        end while (!m_acc && k < 50);
        in_instr_valid = 1'b0;
        if (!m_acc) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: idx %0d never accepted", idx);
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (dlog.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (dlog.size() < n) begin
            errors++;
            $display("FAIL completion_timeout: got %0d completions, expected %0d", dlog.size(), n);
        end
    endtask

    task automatic chk_log(input string name, input int i, input logic [3:0] idx, input logic [15:0] val);
        if (i < dlog.size()) begin
            chk({name, "_idx"}, {12'd0, dlog[i].idx}, {12'd0, idx});
            chk({name, "_val"}, dlog[i].val, val);
        end else begin
            chk({name, "_missing"}, 16'd0, 16'd1);
        end
    endtask

    initial begin
        int n0;
        int t_iss;
        cyc = 0; checks = 0; errors = 0;
        resp_pend = 1'b0; e_valid = 1'b0; e_idx = 4'h0; e_val = 16'h0;
        reset_n = 1'b0; in_instr_valid = 1'b0; in_rob_idx = 4'h0; in_opcode = 4'h0;
        in_a_value = 16'h0; in_b_value = 16'h0; rob_head = 4'h0; flush = 1'b0;

        step();
        step();
        chk("rst_full", {15'd0, full}, 16'd0);
        chk("rst_cdb_valid", {15'd0, cdb_valid}, 16'd0);
        chk("rst_cdb_rob_idx", {12'd0, cdb_rob_idx}, 16'd0);
        chk("rst_cdb_value", cdb_value, 16'd0);
        reset_n = 1'b1;
        step();

        // Store at the ROB head, then a load of the same word
        rob_head = 4'd3;
        issue(4'd3, ST, 16'h0010, 16'hBEEF);
        wait_log(1, 20);
        chk_log("t1_store", 0, 4'd3, 16'h0000);
        issue(4'd4, LD, 16'h0010, 16'h0);
        t_iss = cyc;
        wait_log(2, 20);
        chk_log("t1_load", 1, 4'd4, 16'hBEEF);
        if (dlog.size() > 1) chk("t1_latency", 16'(dlog[1].cyc - t_iss), 16'd2);

        // Store waits for the ROB head; the load behind it waits too
        rob_head = 4'd2;
        n0 = dlog.size();
        issue(4'd5, ST, 16'h0020, 16'h1234);
        repeat (6) step();
        chk("t2_no_early_cdb", 16'(dlog.size()), 16'(n0));
        issue(4'd6, LD, 16'h0020, 16'h0);
        repeat (2) step();
        chk("t2_still_waiting", 16'(dlog.size()), 16'(n0));
        rob_head = 4'd5;
        wait_log(n0 + 2, 20);
        chk_log("t2_store", n0, 4'd5, 16'h0000);
        chk_log("t2_load", n0 + 1, 4'd6, 16'h1234);

        // Queue fills behind a stalled store; later issues are dropped
        rob_head = 4'd0;
        n0 = dlog.size();
        issue(4'd7, ST, 16'h0030, 16'h55AA);
        for (int i = 0; i < 5; i++) issue(4'(8 + i), LD, (i % 2 == 0) ? 16'h0010 : 16'h0020, 16'h0);
        chk("t3_full", {15'd0, full}, 16'd1);
        rob_head = 4'd7;
        wait_log(n0 + 4, 30);
        repeat (10) step();
        chk("t3_completions", 16'(dlog.size() - n0), 16'd4);
        chk_log("t3_store", n0, 4'd7, 16'h0000);
        chk_log("t3_ld8", n0 + 1, 4'd8, 16'hBEEF);
        chk_log("t3_ld10", n0 + 3, 4'd10, 16'hBEEF);

        // Seed words 0..9, then read them back with wrapping pointers
        for (int i = 0; i < 10; i++) begin
            rob_head = 4'(i);
            n0 = dlog.size();
            issue_acc(4'(i), ST, 16'(i), 16'h0100 + 16'(i));
            wait_log(n0 + 1, 20);
        end
        rob_head = 4'hF;
        n0 = dlog.size();
        for (int i = 0; i < 10; i++) issue_acc(4'(i), LD, 16'(i), 16'h0);
        wait_log(n0 + 10, 40);
        for (int i = 0; i < 10; i++) chk_log("t4_load", n0 + i, 4'(i), 16'h0100 + 16'(i));

        // Flush while a store waits, with a same-cycle issue
        rob_head = 4'd0;
        issue(4'd1, ST, 16'h0010, 16'hDEAD);
        issue(4'd2, LD, 16'h0010, 16'h0);
        issue(4'd3, LD, 16'h0020, 16'h0);
        repeat (2) step();
        n0 = dlog.size();
        flush = 1'b1;
        issue(4'd4, LD, 16'h0010, 16'h0);
        flush = 1'b0;
        rob_head = 4'd1;
        chk("t5_full", {15'd0, full}, 16'd0);
        repeat (6) step();
        chk("t5_no_cdb", 16'(dlog.size()), 16'(n0));
        issue(4'd9, LD, 16'h0010, 16'h0);
        wait_log(n0 + 1, 20);
        chk_log("t5_after_flush", n0, 4'd9, 16'hBEEF);

        // Reset while a completion is about to broadcast
        issue(4'd11, LD, 16'h0010, 16'h0);
        step();
        reset_n = 1'b0;
        step();
        chk("t6_cdb_valid", {15'd0, cdb_valid}, 16'd0);
        chk("t6_full", {15'd0, full}, 16'd0);
        reset_n = 1'b1;
        step();
        n0 = dlog.size();
        issue(4'd12, LD, 16'h0010, 16'h0);
        wait_log(n0 + 1, 20);
        chk_log("t6_mem_kept", n0, 4'd12, 16'hBEEF);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            in_instr_valid = ($urandom_range(0, 2) == 0);
            in_rob_idx     = 4'($urandom);
            r              = $urandom_range(0, 3);
            in_opcode      = (r < 2) ? LD : (r == 2) ? ST : OTH;
            in_a_value     = {8'($urandom), 8'($urandom_range(0, 9))};
            in_b_value     = 16'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 1) == 0) rob_head = mq[0].idx;
            else rob_head = 4'($urandom);
            flush = ($urandom_range(0, 99) == 0);
            step();
            flush = 1'b0;
        end
        in_instr_valid = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
